// File: rtl/viterbi_frame_ctl_if.sv
// Handshake and datapath-control bundle between the Viterbi frame sequencer and its
// neighbours (symbol source, BMU/ACS, survivor memory, traceback and output stage).
interface viterbi_frame_ctl_if #(
    parameter int unsigned AW = 8
) ();
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    rx_pair_in;
    logic [1:0]    bmc_rx_pair;
    logic          acs_init;
    logic          acs_en;
    logic          sm_wr_en;
    logic          sm_rd_en;
    logic [AW-1:0] sm_addr;
    logic          tb_load;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic          busy;
    logic          frame_done;

    modport master (
        output start, in_valid, rx_pair_in, out_ready,
        input  in_ready, bmc_rx_pair, acs_init, acs_en, sm_wr_en, sm_rd_en, sm_addr,
               tb_load, out_valid, out_addr, busy, frame_done
    );

    modport slave (
        input  start, in_valid, rx_pair_in, out_ready,
        output in_ready, bmc_rx_pair, acs_init, acs_en, sm_wr_en, sm_rd_en, sm_addr,
               tb_load, out_valid, out_addr, busy, frame_done
    );
endinterface

// File: rtl/viterbi_frame_ctl.sv
// Frame sequencer for the rate-1/2 Viterbi decoder: symbol intake and ACS feed,
// survivor-memory write/traceback addressing, and decoded-bit readout, one frame at a time.
module viterbi_frame_ctl #(
    parameter int unsigned FRAME_LEN = 256,
    parameter int unsigned AW        = 8
) (
    input logic              clk,
    input logic              rst_n,
    viterbi_frame_ctl_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StInit, StAcs, StFlush, StTb, StOut} state_e;

    // Counters carry one extra bit so FRAME_LEN == 2**AW does not alias to zero.
    localparam logic [AW:0]   FrameCnt = (AW+1)'(FRAME_LEN);
    localparam logic [AW-1:0] LastAddr = AW'(FRAME_LEN - 1);

    state_e        state_q, state_d;
    logic [AW:0]   sym_cnt_q, sym_cnt_d;
    logic [AW:0]   wr_cnt_q, wr_cnt_d;
    logic [1:0]    pair_q, pair_d;
    logic          acs_en_q, acs_en_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          load_q, load_d;
    logic [AW-1:0] out_addr_q, out_addr_d;
    logic          done_q, done_d;

    logic in_ready;
    logic accept;
    logic xfer;
    logic last_wr;

    always_comb begin
        state_d    = state_q;
        sym_cnt_d  = sym_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        pair_d     = pair_q;
        acs_en_d   = 1'b0;
        wr_en_d    = 1'b0;
        addr_d     = addr_q;
        load_d     = load_q;
        out_addr_d = out_addr_q;
        done_d     = 1'b0;

        in_ready = (state_q == StAcs) && (sym_cnt_q < FrameCnt);
        accept   = in_ready && bus.in_valid;
        xfer     = (state_q == StOut) && bus.out_ready;
        last_wr  = wr_en_q && (addr_q == LastAddr);

        // Intake pipeline: accept -> acs_en -> survivor write, one stage each.
        if (accept) begin
            pair_d    = bus.rx_pair_in;
            acs_en_d  = 1'b1;
            sym_cnt_d = sym_cnt_q + 1'b1;
        end
        if (acs_en_q) begin
            wr_en_d  = 1'b1;
            addr_d   = wr_cnt_q[AW-1:0];
            wr_cnt_d = wr_cnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                // The frame_done cycle itself cannot restart a frame.
                if (bus.start && !done_q) state_d = StInit;
            end
            StInit: begin
                sym_cnt_d  = '0;
                wr_cnt_d   = '0;
                out_addr_d = '0;
                load_d     = 1'b0;
                state_d    = StAcs;
            end
            StAcs: begin
                if (sym_cnt_q == FrameCnt) state_d = StFlush;
            end
            StFlush: begin
                if (load_q) begin
                    load_d  = 1'b0;
                    addr_d  = LastAddr;
                    state_d = StTb;
                end else if (last_wr) begin
                    load_d = 1'b1;
                end
            end
            StTb: begin
                if (addr_q == '0) begin
                    state_d = StOut;
                end else begin
                    addr_d = addr_q - 1'b1;
                end
            end
            StOut: begin
                if (xfer) begin
                    if (out_addr_q == LastAddr) begin
                        out_addr_d = '0;
                        done_d     = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        out_addr_d = out_addr_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            sym_cnt_q  <= '0;
            wr_cnt_q   <= '0;
            pair_q     <= '0;
            acs_en_q   <= 1'b0;
            wr_en_q    <= 1'b0;
            addr_q     <= '0;
            load_q     <= 1'b0;
            out_addr_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sym_cnt_q  <= sym_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            pair_q     <= pair_d;
            acs_en_q   <= acs_en_d;
            wr_en_q    <= wr_en_d;
            addr_q     <= addr_d;
            load_q     <= load_d;
            out_addr_q <= out_addr_d;
            done_q     <= done_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.bmc_rx_pair = pair_q;
    assign bus.acs_init    = (state_q == StInit);
    assign bus.acs_en      = acs_en_q;
    assign bus.sm_wr_en    = wr_en_q;
    assign bus.sm_rd_en    = (state_q == StTb);
    assign bus.sm_addr     = addr_q;
    assign bus.tb_load     = (state_q == StFlush) && load_q;
    assign bus.out_valid   = (state_q == StOut);
    assign bus.out_addr    = out_addr_q;
    assign bus.busy        = (state_q != StIdle);
    assign bus.frame_done  = done_q;

endmodule

// File: doc/viterbi_frame_ctl.md
Name: viterbi_frame_ctl

Overview:
Frame sequencer for the rate-1/2 Viterbi decoder datapath. It accepts received symbol pairs over a valid/ready handshake and feeds them to the branch-metric unit and ACS array. It drives survivor-memory write addressing, then runs traceback over the stored frame and hands decoded-bit read addresses to the output stage. One frame is in flight at a time.

Parameters:
FRAME_LEN, 256, symbols per frame (≥2)
AW, 8, survivor-memory address width; 2**AW ≥ FRAME_LEN

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin new frame; sampled only in IDLE
in_valid  in  1  rx symbol pair valid
in_ready  out  1  controller accepts rx symbol pair
rx_pair_in  in  2  received symbol pair
bmc_rx_pair  out  2  registered pair to branch-metric unit
acs_init  out  1  clear path metrics (state 0 = 0, others max)
acs_en  out  1  ACS update this cycle using bmc_rx_pair
sm_wr_en  out  1  survivor-memory write strobe
sm_rd_en  out  1  survivor-memory read strobe (traceback)
sm_addr  out  AW  survivor-memory address (shared rd/wr)
tb_load  out  1  traceback unit loads best-metric start state
out_valid  out  1  decoded bit at out_addr is available
out_ready  in  1  downstream consumes decoded bit
out_addr  out  AW  decoded-bit buffer read address
busy  out  1  high in any state except IDLE
frame_done  out  1  one-cycle pulse after last decoded bit consumed

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0, including bmc_rx_pair, sm_addr, out_addr; counters 0.
- States: IDLE -> INIT -> ACS -> FLUSH -> TB -> OUT -> IDLE.
- IDLE: start=1 -> INIT. in_ready=0.
- INIT: exactly one cycle, acs_init=1; -> ACS; sym_cnt=0.
- ACS: in_ready=1 while sym_cnt<FRAME_LEN. Accept = in_valid&in_ready. On accept: bmc_rx_pair<=rx_pair_in, acs_en=1 next cycle (registered, latency 1). sm_wr_en asserts one cycle after acs_en with sm_addr = index of that symbol (0..FRAME_LEN-1). Bubbles (in_valid=0) produce acs_en=0 and no write; addresses stay contiguous. bmc_rx_pair holds its value when no accept.
- After the FRAME_LEN-th accept: in_ready drops the next cycle. Go to FLUSH once the last acs_en has been issued.
- FLUSH: waits until the final sm_wr_en (addr FRAME_LEN-1) has fired, then one cycle with tb_load=1 -> TB.
- TB: FRAME_LEN consecutive cycles, sm_rd_en=1, sm_addr counting down FRAME_LEN-1 .. 0, no stalls. Then -> OUT.
- OUT: out_valid=1, out_addr starts at 0 and increments on each out_valid&out_ready. Decoded bits are stored in traceback order, so the output stage reverses them. Stalls hold out_addr. After the transfer at out_addr=FRAME_LEN-1: frame_done pulses for 1 cycle, out_valid=0, -> IDLE.
- start outside IDLE is ignored. No same-cycle back-to-back: the earliest restart is start in the cycle after frame_done.
- sm_wr_en and sm_rd_en are never high together. acs_en never asserts outside ACS/FLUSH.
- Counters are AW+1 bits internally, so FRAME_LEN = 2**AW does not alias. sm_addr never exceeds FRAME_LEN-1.
- Reset mid-frame: immediate return to IDLE with all outputs 0. A partial frame is discarded and survivor-memory contents are irrelevant.

Test Plan:
- Reset, then start, FRAME_LEN=4, in_valid held 1, pairs 00,11,01,10 -> acs_init 1 cycle. acs_en cycles carry bmc_rx_pair 00,11,01,10 in order. sm_wr_en addrs 0,1,2,3, each one cycle after its acs_en. in_ready low after the 4th accept.
- Same frame with in_valid bubbles (valid pattern 1,0,0,1,1,0,1) -> exactly 4 acs_en and 4 writes, addrs 0..3 contiguous, bmc_rx_pair stable across bubbles.
- Traceback -> tb_load 1 cycle after the write to addr 3, then 4 cycles of sm_rd_en with addrs 3,2,1,0. No overlap with sm_wr_en.
- Output with out_ready pattern 1,0,1,1,0,1 -> out_addr 0,1,1,2,3,3 on successive cycles. frame_done pulses the cycle after the addr-3 transfer. busy=0 after.
- start pulsed during ACS and TB -> no effect. Second frame started right after frame_done completes identically, with addresses restarting at 0.
- rst_n asserted mid-TB -> outputs 0 asynchronously. After release, start runs a full correct frame. FRAME_LEN=256, AW=8 -> final write addr 255, traceback starts at 255, no wrap.
